// File: rtl/state_sequencer_pkg.sv
// Shared encodings for the instruction sequencer and the control unit:
// state codes, instruction type/function codes, return-stack limit.
package state_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_TRAP = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    TYPE_R = 2'b00,
    TYPE_I = 2'b01,
    TYPE_J = 2'b10,
    TYPE_S = 2'b11
  } inst_type_t;

  localparam logic [4:0] FN_AND  = 5'd0;
  localparam logic [4:0] FN_ADD  = 5'd1;
  localparam logic [4:0] FN_SUB  = 5'd2;
  localparam logic [4:0] FN_CMP  = 5'd3;

  localparam logic [4:0] FN_ANDI = 5'd0;
  localparam logic [4:0] FN_ADDI = 5'd1;
  localparam logic [4:0] FN_LW   = 5'd2;
  localparam logic [4:0] FN_SW   = 5'd3;
  localparam logic [4:0] FN_BEQ  = 5'd4;

  localparam logic [4:0] FN_J    = 5'd0;
  localparam logic [4:0] FN_JAL  = 5'd1;

  localparam logic [4:0] FN_SLL  = 5'd0;
  localparam logic [4:0] FN_SLR  = 5'd1;

  localparam logic [3:0] STACK_MAX = 4'd8;

endpackage

// File: rtl/state_sequencer_inst_classify.sv
// Opcode legality and execution-path classifier for one (type, function) pair.
module inst_classify
  import state_sequencer_pkg::*;
(
  input  logic [1:0] inst_type,
  input  logic [4:0] inst_function,
  output logic       legal,
  output logic       is_jal,
  output logic       needs_mem,
  output logic       needs_wb,
  output logic       ends_in_ex
);

  always_comb begin
    legal      = 1'b0;
    is_jal     = 1'b0;
    needs_mem  = 1'b0;
    needs_wb   = 1'b0;
    ends_in_ex = 1'b0;
    case (inst_type_t'(inst_type))
      TYPE_R: begin
        legal    = (inst_function <= FN_CMP);
        needs_wb = legal;
      end
      TYPE_S: begin
        legal    = (inst_function <= FN_SLR);
        needs_wb = legal;
      end
      TYPE_I: begin
        case (inst_function)
          FN_ANDI, FN_ADDI: begin
            legal    = 1'b1;
            needs_wb = 1'b1;
          end
          FN_LW: begin
            legal     = 1'b1;
            needs_mem = 1'b1;
            needs_wb  = 1'b1;
          end
          FN_SW: begin
            legal     = 1'b1;
            needs_mem = 1'b1;
          end
          FN_BEQ: begin
            legal      = 1'b1;
            ends_in_ex = 1'b1;
          end
          default: ;
        endcase
      end
      TYPE_J: begin
        legal  = (inst_function <= FN_JAL);
        is_jal = (inst_function == FN_JAL);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/state_sequencer.sv
// Multi-cycle instruction sequencer: IF/ID/EX/MEM/WB walk, return-stack depth
// tracking, retirement counter, sticky HALT/TRAP.
module state_sequencer
  import state_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  inst_type,
  input  logic [4:0]  inst_function,
  input  logic        stop_bit,
  output logic [2:0]  state,
  output logic [2:0]  next_state,
  output logic        ir_write,
  output logic        instr_done,
  output logic [3:0]  stack_depth,
  output logic [15:0] retired,
  output logic        halted,
  output logic        trap
);

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] depth_nxt;
  logic       complete;
  logic       retire;
  logic       legal, is_jal, needs_mem, needs_wb, ends_in_ex;

  inst_classify u_classify (
    .inst_type     (inst_type),
    .inst_function (inst_function),
    .legal         (legal),
    .is_jal        (is_jal),
    .needs_mem     (needs_mem),
    .needs_wb      (needs_wb),
    .ends_in_ex    (ends_in_ex)
  );

  // Path selection first, then a shared completion stage that resolves
  // push/pop/halt so every terminal state funnels through one place.
  always_comb begin
    nxt_state = cur_state;
    depth_nxt = stack_depth;
    complete  = 1'b0;
    retire    = 1'b0;
    case (cur_state)
      S_IF:  nxt_state = S_ID;
      S_ID: begin
        if (!legal)                                nxt_state = S_TRAP;
        else if (inst_type_t'(inst_type) == TYPE_J) complete  = 1'b1;
        else                                       nxt_state = S_EX;
      end
      S_EX: begin
        if (needs_mem)       nxt_state = S_MEM;
        else if (needs_wb)   nxt_state = S_WB;
        else if (ends_in_ex) complete  = 1'b1;
        else                 nxt_state = S_TRAP;
      end
      S_MEM: begin
        if (needs_mem && needs_wb) nxt_state = S_WB;
        else if (needs_mem)        complete  = 1'b1;
        else                       nxt_state = S_TRAP;
      end
      S_WB:   complete  = 1'b1;
      S_HALT: nxt_state = S_HALT;
      S_TRAP: nxt_state = S_TRAP;
      default: nxt_state = S_TRAP;
    endcase

    if (complete) begin
      if (is_jal) begin
        if (stack_depth >= STACK_MAX) begin
          nxt_state = S_TRAP;
        end else begin
          depth_nxt = stack_depth + 4'd1;
          nxt_state = S_IF;
          retire    = 1'b1;
        end
      end else if (stop_bit) begin
        retire = 1'b1;
        if (stack_depth != '0) begin
          depth_nxt = stack_depth - 4'd1;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_HALT;
        end
      end else begin
        retire    = 1'b1;
        nxt_state = S_IF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state   <= S_IF;
      stack_depth <= '0;
      retired     <= '0;
    end else begin
      cur_state   <= nxt_state;
      stack_depth <= depth_nxt;
      if (retire) retired <= retired + 16'd1;
    end
  end

  assign state      = cur_state;
  assign next_state = nxt_state;
  assign ir_write   = (cur_state == S_IF);
  assign instr_done = retire;
  assign halted     = (cur_state == S_HALT);
  assign trap       = (cur_state == S_TRAP);

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer: fixed vector table, directed corner
// sequences and a randomized run against an instruction-level reference model.
module tb_state_sequencer;

  logic        clk;
  logic        reset;
  logic [1:0]  inst_type;
  logic [4:0]  inst_function;
  logic        stop_bit;
  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        ir_write;
  logic        instr_done;
  logic [3:0]  stack_depth;
  logic [15:0] retired;
  logic        halted;
  logic        trap;

  int unsigned total;
  int unsigned bad;

  int          m_depth;
  logic [15:0] m_retired;
  bit          m_halt;
  bit          m_trap;

  logic [2:0]  trace[$];

  typedef struct {
    logic [1:0]  t;
    logic [4:0]  f;
    logic        s;
    int          n;
    bit          d;
    logic [2:0]  st;
    logic [3:0]  dep;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[11];

  state_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .inst_type     (inst_type),
    .inst_function (inst_function),
    .stop_bit      (stop_bit),
    .state         (state),
    .next_state    (next_state),
    .ir_write      (ir_write),
    .instr_done    (instr_done),
    .stack_depth   (stack_depth),
    .retired       (retired),
    .halted        (halted),
    .trap          (trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] t, input logic [4:0] f);
    case (t)
      2'd0:    return f < 5'd4;
      2'd1:    return f < 5'd5;
      default: return f < 5'd2;
    endcase
  endfunction

  // Cycles per instruction from the ISA timing table.
  function automatic int cpi(input logic [1:0] t, input logic [4:0] f);
    if (t == 2'd2) return 2;
    if (t == 2'd1 && f == 5'd4) return 3;
    if (t == 2'd1 && f == 5'd2) return 5;
    return 4;
  endfunction

  task automatic model_reset();
    m_depth   = 0;
    m_retired = 16'd0;
    m_halt    = 1'b0;
    m_trap    = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] t, input logic [4:0] f, input logic s,
                             output int exp_n, output bit exp_d);
    bit jal;
    jal   = (t == 2'd2 && f == 5'd1);
    exp_d = 1'b1;
    if (!is_legal(t, f)) begin
      m_trap = 1'b1;
      exp_n  = 2;
      exp_d  = 1'b0;
      return;
    end
    exp_n = cpi(t, f);
    if (jal) begin
      if (m_depth == 8) begin
        m_trap = 1'b1;
        exp_d  = 1'b0;
      end else begin
        m_depth++;
      end
    end else if (s) begin
      if (m_depth > 0) m_depth--;
      else             m_halt = 1'b1;
    end
    if (exp_d) m_retired = m_retired + 16'd1;
  endtask

  // Starts at a falling edge with state IF; returns at a falling edge.
  task automatic run_instr(input logic [1:0] t, input logic [4:0] f, input logic s,
                           output int n, output bit d);
    inst_type     = t;
    inst_function = f;
    stop_bit      = s;
    n = 0;
    d = 1'b0;
    trace.delete();
    repeat (20) begin
      n++;
      trace.push_back(state);
      d = instr_done;
      @(posedge clk);
      @(negedge clk);
      if (d || state == 3'd5 || state == 3'd6) break;
    end
  endtask

  function automatic logic [14:0] pack_trace();
    logic [14:0] v;
    v = '1;
    for (int i = 0; i < 5 && i < trace.size(); i++) v[(4 - i) * 3 +: 3] = trace[i];
    return v;
  endfunction

  task automatic exec_and_check(input string name, input logic [1:0] t, input logic [4:0] f,
                                input logic s);
    int exp_n, n;
    bit exp_d, d;
    model_apply(t, f, s, exp_n, exp_d);
    run_instr(t, f, s, n, d);
    check({name, ".cycles"}, 32'(n), 32'(exp_n));
    check({name, ".done"}, 32'(d), 32'(exp_d));
    check({name, ".state"}, 32'(state), m_trap ? 32'd6 : (m_halt ? 32'd5 : 32'd0));
    check({name, ".depth"}, 32'(stack_depth), 32'(m_depth));
    check({name, ".retired"}, 32'(retired), 32'(m_retired));
    check({name, ".halted"}, 32'(halted), 32'(m_halt));
    check({name, ".trap"}, 32'(trap), 32'(m_trap));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_type = 2'd0; inst_function = 5'd0; stop_bit = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle_absorb(input string name, input logic [2:0] exp_state);
    repeat (4) begin
      inst_type     = 2'($urandom_range(0, 3));
      inst_function = 5'($urandom_range(0, 31));
      stop_bit      = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    check({name, ".sticky_state"}, 32'(state), 32'(exp_state));
    check({name, ".sticky_retired"}, 32'(retired), 32'(m_retired));
    check({name, ".sticky_depth"}, 32'(stack_depth), 32'(m_depth));
  endtask

  initial begin
    int n, n2;
    bit d;
    logic [1:0] t;
    logic [4:0] f;
    logic       s;
    int unsigned r;

    total = 0;
    bad   = 0;
    tbl[0]  = '{2'd0, 5'd1, 1'b0, 4, 1'b1, 3'd0, 4'd0, 16'd1};
    tbl[1]  = '{2'd1, 5'd2, 1'b0, 5, 1'b1, 3'd0, 4'd0, 16'd2};
    tbl[2]  = '{2'd1, 5'd3, 1'b0, 4, 1'b1, 3'd0, 4'd0, 16'd3};
    tbl[3]  = '{2'd1, 5'd4, 1'b0, 3, 1'b1, 3'd0, 4'd0, 16'd4};
    tbl[4]  = '{2'd2, 5'd1, 1'b1, 2, 1'b1, 3'd0, 4'd1, 16'd5};
    tbl[5]  = '{2'd2, 5'd1, 1'b0, 2, 1'b1, 3'd0, 4'd2, 16'd6};
    tbl[6]  = '{2'd3, 5'd0, 1'b1, 4, 1'b1, 3'd0, 4'd1, 16'd7};
    tbl[7]  = '{2'd1, 5'd1, 1'b1, 4, 1'b1, 3'd0, 4'd0, 16'd8};
    tbl[8]  = '{2'd2, 5'd0, 1'b0, 2, 1'b1, 3'd0, 4'd0, 16'd9};
    tbl[9]  = '{2'd0, 5'd3, 1'b0, 4, 1'b1, 3'd0, 4'd0, 16'd10};
    tbl[10] = '{2'd2, 5'd0, 1'b1, 2, 1'b1, 3'd5, 4'd0, 16'd11};

    reset = 1'b1;
    inst_type = 2'd0; inst_function = 5'd0; stop_bit = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset.state", 32'(state), 32'd0);
    check("reset.ir_write", 32'(ir_write), 32'd1);
    check("reset.depth", 32'(stack_depth), 32'd0);
    check("reset.retired", 32'(retired), 32'd0);
    check("reset.halted", 32'(halted), 32'd0);
    check("reset.trap", 32'(trap), 32'd0);
    check("reset.instr_done", 32'(instr_done), 32'd0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      run_instr(tbl[i].t, tbl[i].f, tbl[i].s, n, d);
      check($sformatf("tbl%0d.cycles", i), 32'(n), 32'(tbl[i].n));
      check($sformatf("tbl%0d.done", i), 32'(d), 32'(tbl[i].d));
      check($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("tbl%0d.depth", i), 32'(stack_depth), 32'(tbl[i].dep));
      check($sformatf("tbl%0d.retired", i), 32'(retired), 32'(tbl[i].ret));
    end
    m_retired = 16'd11;
    idle_absorb("tbl_halt", 3'd5);
    check("tbl_halt.halted", 32'(halted), 32'd1);

    // ADD from reset: state walk 0,1,2,4
    do_reset();
    run_instr(2'd0, 5'd1, 1'b0, n, d);
    check("add.trace", 32'(pack_trace()), 32'(15'b000_001_010_100_111));
    check("add.done", 32'(d), 32'd1);
    check("add.retired", 32'(retired), 32'd1);

    // LW then SW: 9 cycles total
    do_reset();
    run_instr(2'd1, 5'd2, 1'b0, n, d);
    check("lw.trace", 32'(pack_trace()), 32'(15'b000_001_010_011_100));
    run_instr(2'd1, 5'd3, 1'b0, n2, d);
    check("sw.trace", 32'(pack_trace()), 32'(15'b000_001_010_011_111));
    check("lwsw.cycles", 32'(n + n2), 32'd9);
    check("lwsw.retired", 32'(retired), 32'd2);

    // Return-stack overflow on the ninth JAL
    do_reset();
    for (int i = 0; i < 8; i++) exec_and_check($sformatf("jal%0d", i), 2'd2, 5'd1, 1'b0);
    exec_and_check("jal_ovf", 2'd2, 5'd1, 1'b0);
    idle_absorb("jal_ovf", 3'd6);
    check("jal_ovf.trap", 32'(trap), 32'd1);

    // Call/return then halt at depth 0
    do_reset();
    exec_and_check("call", 2'd2, 5'd1, 1'b0);
    exec_and_check("ret", 2'd0, 5'd1, 1'b1);
    exec_and_check("halt", 2'd2, 5'd0, 1'b1);
    check("halt.retired3", 32'(retired), 32'd3);
    idle_absorb("halt", 3'd5);

    // Illegal opcode, then asynchronous reset in the middle of EX
    do_reset();
    exec_and_check("illegal", 2'd1, 5'd7, 1'b0);
    idle_absorb("illegal", 3'd6);
    do_reset();
    exec_and_check("pre_rst_jal", 2'd2, 5'd1, 1'b0);
    inst_type = 2'd0; inst_function = 5'd1; stop_bit = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_ex.state", 32'(state), 32'd2);
    reset = 1'b1;
    #1;
    check("async_rst.state", 32'(state), 32'd0);
    check("async_rst.depth", 32'(stack_depth), 32'd0);
    check("async_rst.retired", 32'(retired), 32'd0);
    check("async_rst.ir_write", 32'(ir_write), 32'd1);
    @(posedge clk);
    #1;
    check("rst_hold.state", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.state", 32'(state), 32'd1);
    check("post_rst.retired", 32'(retired), 32'd0);

    // Retirement counter wrap
    do_reset();
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    m_retired = 16'hFFFF;
    exec_and_check("wrap", 2'd0, 5'd1, 1'b0);

    // Randomized run against the reference model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        t = 2'd2; f = 5'd1;
      end else if (r < 33) begin
        t = 2'($urandom_range(0, 3));
        f = 5'($urandom_range(t == 2'd0 ? 4 : (t == 2'd1 ? 5 : 2), 31));
      end else begin
        t = 2'($urandom_range(0, 3));
        case (t)
          2'd0:    f = 5'($urandom_range(0, 3));
          2'd1:    f = 5'($urandom_range(0, 4));
          default: f = 5'($urandom_range(0, 1));
        endcase
      end
      s = ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0;
      exec_and_check($sformatf("rnd%0d", k), t, f, s);
      if (m_halt || m_trap) begin
        idle_absorb($sformatf("rnd%0d", k), m_trap ? 3'd6 : 3'd5);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port inst_type, input, 2 bits: 00 R, 01 I, 10 J, 11 S.
REQ-004 SHALL have port inst_function, input, 5 bits: opcode within type; sampled in ID/EX/MEM.
REQ-005 SHALL have port stop_bit, input, 1 bit: instruction ends the current function; pop return on completion.
REQ-006 SHALL have port state, output, 3 bits: registered current state, fed to the control unit.
REQ-007 SHALL have port next_state, output, 3 bits: combinational next value of state.
REQ-008 SHALL have port ir_write, output, 1 bit: high while state==IF.
REQ-009 SHALL have port instr_done, output, 1 bit: high in the last cycle of an instruction.
REQ-010 SHALL have port stack_depth, output, 4 bits: return-stack occupancy, 0..8.
REQ-011 SHALL have port retired, output, 16 bits: count of completed instructions.
REQ-012 SHALL have port halted, output, 1 bit: program finished, sticky.
REQ-013 SHALL have port trap, output, 1 bit: illegal opcode or stack overflow, sticky.

Function
REQ-014 SHALL encode states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, TRAP=6; code 7 SHALL go to TRAP.
REQ-015 SHALL have legal functions: R {0 AND, 1 ADD, 2 SUB, 3 CMP}; I {0 ANDI, 1 ADDI, 2 LW, 3 SW, 4 BEQ}; J {0 J, 1 JAL}; S {0 SLL, 1 SLR}; any other (type,function) SHALL be illegal.
REQ-016 SHALL transition IF->ID unconditionally.
REQ-017 SHALL transition ID: illegal -> TRAP; J-type -> instruction complete; else -> EX.
REQ-018 SHALL transition EX: R, S, ANDI, ADDI -> WB; LW, SW -> MEM; BEQ -> complete.
REQ-019 SHALL transition MEM: LW -> WB; SW -> complete.
REQ-020 SHALL treat WB as complete.
REQ-021 SHALL drive instr_done=1 exactly in the complete cycle, one cycle per instruction.
REQ-022 SHALL, on completion, increment retired by 1 with mod-2^16 wrap (0xFFFF -> 0x0000).
REQ-023 SHALL, on completion of JAL, push: depth+1; completing JAL at depth 8 -> TRAP, depth unchanged, retired not incremented.
REQ-024 SHALL, on completion with stop_bit=1 (not JAL), pop: depth>0 -> depth-1, next IF; depth==0 -> HALT, retired incremented.
REQ-025 SHALL treat JAL with stop_bit=1 as a push only; stop_bit ignored.
REQ-026 SHALL otherwise go from completion to IF.
REQ-027 SHALL make HALT and TRAP absorbing until reset; halted = (state==HALT), trap = (state==TRAP); no counter changes there.
REQ-028 SHALL compute next_state combinationally from state, inst_type, inst_function, stop_bit and stack_depth; state <= next_state each edge.
REQ-029 SHALL give a CPI of: J 2; BEQ 3; R/S/ANDI/ADDI 4; SW 4; LW 5.

Reset
REQ-030 SHALL, on reset assertion, immediately set state=IF, stack_depth=0, retired=0, halted=0, trap=0, regardless of clk.
REQ-031 SHALL, on reset mid-instruction, abandon the instruction with no completion, push or pop; first post-reset edge goes IF->ID.
REQ-032 SHALL, while reset is held, hold outputs at reset values; ir_write=1 (state==IF).

Structure
REQ-033 SHALL keep the state codes, inst_type codes, function codes and STACK_MAX=8 in a shared package, also used by the control unit.
REQ-034 SHALL place the opcode-legality/path classifier in one combinational sub-module inst_classify with outputs legal, is_jal, needs_mem, needs_wb, ends_in_ex.
REQ-035 SHALL contain no memory; the return-address storage belongs to the datapath and this block tracks depth only.

Verification
REQ-036 SHALL cover: ADD (type 00 fn 1), stop 0, from reset -> states 0,1,2,4; instr_done in cycle 4; retired=1.
REQ-037 SHALL cover: LW then SW -> LW 0,1,2,3,4 and SW 0,1,2,3; retired=2 after 9 cycles.
REQ-038 SHALL cover: 8 JALs -> depth=8; 9th JAL -> TRAP at its ID-complete edge, depth stays 8, trap=1 until reset.
REQ-039 SHALL cover: JAL, then ADD with stop 1 -> depth 1->0, IF; then J with stop 1 at depth 0 -> HALT, halted=1, retired=3.
REQ-040 SHALL cover: type 01 fn 7 -> TRAP from ID; retired unchanged; then pulse reset mid-EX of an ADD -> state=0 immediately, counters 0.
REQ-041 SHALL cover: preload 65535 retirements (or force) then ADD -> retired=0x0000, no TRAP.
